// File: rtl/dijkstra_pkg.sv
// rtl/dijkstra_pkg.sv - shared types and defaults for the Dijkstra result writer
package dijkstra_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    ADVANCE = 2'd2,
    DONE    = 2'd3
  } writer_state_t;

  localparam logic [1:0] MODE_PREV = 2'b01;
  localparam logic [1:0] MODE_DIST = 2'b10;

  localparam int DEFAULT_MAX_NODES   = 16;
  localparam int DEFAULT_INDEX_WIDTH = 8;
  localparam int DEFAULT_VALUE_WIDTH = 16;
  localparam int DEFAULT_MADDR_WIDTH = 32;
  localparam int DEFAULT_MDATA_WIDTH = 32;
  localparam int DEFAULT_PACK        = 2;

endpackage

// File: rtl/dijkstra_result_writer_word_packer.sv
// rtl/dijkstra_result_writer_word_packer.sv - packs PACK elements of a vector into one memory word
module word_packer #(
  parameter int MAX_NODES   = 16,
  parameter int ELEM_WIDTH  = 8,
  parameter int MDATA_WIDTH = 32,
  parameter int PACK        = 2,
  parameter int WORD_W      = 5,
  parameter int CNT_W       = 5
) (
  input  logic [MAX_NODES*ELEM_WIDTH-1:0] vector,
  input  logic [WORD_W-1:0]               word_index,
  input  logic [CNT_W-1:0]                n,
  output logic [MDATA_WIDTH-1:0]          word
);

  localparam int SLOT_WIDTH = MDATA_WIDTH / PACK;

  // Constant-index mux over all elements; slots past n stay zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < PACK; k++) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        if ((int'(word_index) * PACK + k == i) && (i < int'(n))) begin
          word[k*SLOT_WIDTH +: SLOT_WIDTH] = SLOT_WIDTH'(vector[i*ELEM_WIDTH +: ELEM_WIDTH]);
        end
      end
    end
  end

endmodule

// File: rtl/dijkstra_result_writer.sv
// rtl/dijkstra_result_writer.sv - streams predecessor/distance vectors to memory over an Avalon-MM write master
module dijkstra_result_writer
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int PACK        = DEFAULT_PACK
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [1:0]                       mode,
  input  logic [MADDR_WIDTH-1:0]           prev_base,
  input  logic [MADDR_WIDTH-1:0]           dist_base,
  input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
  input  logic [MAX_NODES*INDEX_WIDTH-1:0] prev_vector,
  input  logic [MAX_NODES*VALUE_WIDTH-1:0] dist_vector,
  output logic                             avm_write,
  output logic [MADDR_WIDTH-1:0]           avm_address,
  output logic [MDATA_WIDTH-1:0]           avm_writedata,
  output logic [MDATA_WIDTH/8-1:0]         avm_byteenable,
  input  logic                             avm_waitrequest,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted
);

  localparam int BYTES      = MDATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(BYTES);
  localparam int SLOT_WIDTH = MDATA_WIDTH / PACK;
  localparam int CNT_W      = $clog2(MAX_NODES + 1);
  localparam int WORD_W     = $clog2(MAX_NODES + 1);
  localparam logic [MADDR_WIDTH-1:0] ALIGN_MASK = ~MADDR_WIDTH'(BYTES - 1);

  if (MDATA_WIDTH % PACK != 0) begin : g_bad_pack
    $error("MDATA_WIDTH must be a multiple of PACK");
  end
  if (SLOT_WIDTH < INDEX_WIDTH || SLOT_WIDTH < VALUE_WIDTH) begin : g_bad_slot
    $error("slot width too narrow for INDEX_WIDTH/VALUE_WIDTH");
  end

  writer_state_t           state_q, state_d;
  logic [1:0]              mode_q;
  logic [MADDR_WIDTH-1:0]  prev_base_q, dist_base_q;
  logic [CNT_W-1:0]        n_q, n_start, n_sel;
  logic                    ch_q, ch_d;
  logic [WORD_W-1:0]       w_q, w_d, words;
  logic                    load, write_d, busy_d, done_d, aborted_d;
  logic [MADDR_WIDTH-1:0]  base_sel, addr_d;
  logic [MDATA_WIDTH-1:0]  prev_word, dist_word, data_d;

  assign avm_byteenable = '1;

  always_comb begin
    if (int'(number_of_nodes) > MAX_NODES) n_start = CNT_W'(MAX_NODES);
    else                                   n_start = CNT_W'(number_of_nodes);
  end

  // In IDLE the first word is built from the live inputs, since latching happens on the same edge.
  assign n_sel = (state_q == IDLE) ? n_start : n_q;
  assign words = WORD_W'((int'(n_q) + PACK - 1) / PACK);

  always_comb begin
    if (state_q == IDLE) base_sel = ch_d ? (dist_base & ALIGN_MASK) : (prev_base & ALIGN_MASK);
    else                 base_sel = ch_d ? dist_base_q : prev_base_q;
  end
  assign addr_d = base_sel + (MADDR_WIDTH'(w_d) << ADDR_LSB);
  assign data_d = ch_d ? dist_word : prev_word;

  word_packer #(
    .MAX_NODES(MAX_NODES), .ELEM_WIDTH(INDEX_WIDTH), .MDATA_WIDTH(MDATA_WIDTH),
    .PACK(PACK), .WORD_W(WORD_W), .CNT_W(CNT_W)
  ) u_prev_packer (
    .vector(prev_vector), .word_index(w_d), .n(n_sel), .word(prev_word)
  );

  word_packer #(
    .MAX_NODES(MAX_NODES), .ELEM_WIDTH(VALUE_WIDTH), .MDATA_WIDTH(MDATA_WIDTH),
    .PACK(PACK), .WORD_W(WORD_W), .CNT_W(CNT_W)
  ) u_dist_packer (
    .vector(dist_vector), .word_index(w_d), .n(n_sel), .word(dist_word)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    w_d       = w_q;
    load      = 1'b0;
    write_d   = avm_write;
    busy_d    = busy;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        write_d = 1'b0;
        if (start) begin
          if ((mode & (MODE_PREV | MODE_DIST)) == 2'b00 || n_start == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            ch_d    = ((mode & MODE_PREV) == 2'b00);
            w_d     = '0;
            load    = 1'b1;
            write_d = 1'b1;
            busy_d  = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          if (abort) begin
            state_d   = DONE;
            write_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end else if (w_q + WORD_W'(1) < words) begin
            w_d  = w_q + WORD_W'(1);
            load = 1'b1;
          end else if (!ch_q && ((mode_q & MODE_DIST) != 2'b00)) begin
            // Channel switch: preload dist word 0 while the bus idles for one cycle.
            ch_d    = 1'b1;
            w_d     = '0;
            load    = 1'b1;
            write_d = 1'b0;
            state_d = ADVANCE;
          end else begin
            state_d = DONE;
            write_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ADVANCE: begin
        if (abort) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          write_d = 1'b1;
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        write_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= '0;
      prev_base_q   <= '0;
      dist_base_q   <= '0;
      n_q           <= '0;
      ch_q          <= 1'b0;
      w_q           <= '0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      w_q       <= w_d;
      avm_write <= write_d;
      busy      <= busy_d;
      done      <= done_d;
      aborted   <= aborted_d;
      if (state_q == IDLE && start) begin
        mode_q      <= mode;
        prev_base_q <= prev_base & ALIGN_MASK;
        dist_base_q <= dist_base & ALIGN_MASK;
        n_q         <= n_start;
      end
      if (load) begin
        avm_address   <= addr_d;
        avm_writedata <= data_d;
      end
    end
  end

endmodule
